// File: rtl/sb_pkg.sv
// Shared definitions for the bulls-and-cows judge and its LCD stage.
package sb_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int DIGIT_MAX  = 9;
  localparam int CNT_W      = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    JUDGE   = 3'd2,
    WIN_ST  = 3'd3,
    LOSE_ST = 3'd4
  } state_t;

  // A secret is usable only with three BCD digits that are all different.
  function automatic logic secret_ok(input logic [NUM_DIGITS*DIGIT_W-1:0] sec);
    logic [DIGIT_W-1:0] d0;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d2;
    d0 = sec[11:8];
    d1 = sec[7:4];
    d2 = sec[3:0];
    return (d0 <= 4'(DIGIT_MAX)) && (d1 <= 4'(DIGIT_MAX)) && (d2 <= 4'(DIGIT_MAX)) &&
           (d0 != d1) && (d0 != d2) && (d1 != d2);
  endfunction

endpackage

// File: rtl/sb_digit_cmp.sv
// Classifies one guess digit against the secret: strike, ball or nothing.
module sb_digit_cmp
  import sb_pkg::*;
(
  input  logic [DIGIT_W-1:0]            digit,
  input  logic [1:0]                    pos,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
  output logic                          strike,
  output logic                          ball
);

  logic [NUM_DIGITS-1:0] match_s;
  logic [NUM_DIGITS-1:0] pos_oh_s;

  // Match the digit against every secret position and split by position.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      match_s[i] = (secret[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] == digit);
    end
    case (pos)
      2'd0:    pos_oh_s = 3'b001;
      2'd1:    pos_oh_s = 3'b010;
      2'd2:    pos_oh_s = 3'b100;
      default: pos_oh_s = 3'b000;
    endcase
    strike = |(match_s & pos_oh_s);
    ball   = |(match_s & ~pos_oh_s);
  end

endmodule

// File: rtl/sb_judge.sv
// Game controller: collects a three-digit guess and judges it over three cycles.
module sb_judge
  import sb_pkg::*;
#(
  parameter int MAX_TRY = 9
)
(
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          SECRET_LOAD,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] SECRET,
  input  logic                          KEY_VALID,
  input  logic [DIGIT_W-1:0]            KEY_DIGIT,
  input  logic                          KEY_CLEAR,
  output logic [CNT_W-1:0]              S,
  output logic [CNT_W-1:0]              B,
  output logic                          RESULT_VALID,
  output logic [3:0]                    TRY_CNT,
  output logic                          WIN,
  output logic                          LOSE,
  output logic                          BUSY
);

  state_t                        state_r;
  logic [NUM_DIGITS*DIGIT_W-1:0] secret_r;
  logic [NUM_DIGITS*DIGIT_W-1:0] guess_r;
  logic [1:0]                    guess_cnt_r;
  logic [1:0]                    jcnt_r;
  logic [1:0]                    s_acc_r;
  logic [1:0]                    b_acc_r;

  logic                          secret_ok_s;
  logic                          dup_s;
  logic                          key_ok_s;
  logic [DIGIT_W-1:0]            cur_digit_s;
  logic                          strike_s;
  logic                          ball_s;
  logic [1:0]                    s_tot_s;
  logic [1:0]                    b_tot_s;
  logic [3:0]                    try_next_s;

  assign secret_ok_s = secret_ok(SECRET);
  assign key_ok_s    = (KEY_DIGIT <= 4'(DIGIT_MAX)) && !dup_s;
  assign s_tot_s     = s_acc_r + {1'b0, strike_s};
  assign b_tot_s     = b_acc_r + {1'b0, ball_s};
  assign try_next_s  = TRY_CNT + 4'd1;

  // Flag a key digit that repeats one already held in the partial guess.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dup_s = dup_s | ((2'(i) < guess_cnt_r) &&
                       (guess_r[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] == KEY_DIGIT));
    end
  end

  // Select the guess digit compared in the current judge cycle.
  always_comb begin
    case (jcnt_r)
      2'd0:    cur_digit_s = guess_r[11:8];
      2'd1:    cur_digit_s = guess_r[7:4];
      2'd2:    cur_digit_s = guess_r[3:0];
      default: cur_digit_s = 4'd0;
    endcase
  end

  sb_digit_cmp u_cmp (
    .digit  (cur_digit_s),
    .pos    (jcnt_r),
    .secret (secret_r),
    .strike (strike_s),
    .ball   (ball_s)
  );

  // Game FSM with all outputs registered; a valid secret load overrides everything.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r      <= IDLE;
      secret_r     <= '0;
      guess_r      <= '0;
      guess_cnt_r  <= 2'd0;
      jcnt_r       <= 2'd0;
      s_acc_r      <= 2'd0;
      b_acc_r      <= 2'd0;
      S            <= '0;
      B            <= '0;
      RESULT_VALID <= 1'b0;
      TRY_CNT      <= 4'd0;
      WIN          <= 1'b0;
      LOSE         <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      RESULT_VALID <= 1'b0;
      if (SECRET_LOAD && secret_ok_s) begin
        state_r     <= COLLECT;
        secret_r    <= SECRET;
        guess_r     <= '0;
        guess_cnt_r <= 2'd0;
        jcnt_r      <= 2'd0;
        s_acc_r     <= 2'd0;
        b_acc_r     <= 2'd0;
        S           <= '0;
        B           <= '0;
        TRY_CNT     <= 4'd0;
        WIN         <= 1'b0;
        LOSE        <= 1'b0;
        BUSY        <= 1'b0;
      end else begin
        case (state_r)
          COLLECT: begin
            if (KEY_CLEAR) begin
              guess_r     <= '0;
              guess_cnt_r <= 2'd0;
            end else if (KEY_VALID && key_ok_s) begin
              case (guess_cnt_r)
                2'd0:    guess_r[11:8] <= KEY_DIGIT;
                2'd1:    guess_r[7:4]  <= KEY_DIGIT;
                default: guess_r[3:0]  <= KEY_DIGIT;
              endcase
              if (guess_cnt_r == 2'd2) begin
                state_r <= JUDGE;
                BUSY    <= 1'b1;
                jcnt_r  <= 2'd0;
                s_acc_r <= 2'd0;
                b_acc_r <= 2'd0;
              end else begin
                guess_cnt_r <= guess_cnt_r + 2'd1;
              end
            end
          end
          JUDGE: begin
            if (jcnt_r == 2'd2) begin
              S            <= {{(CNT_W-2){1'b0}}, s_tot_s};
              B            <= {{(CNT_W-2){1'b0}}, b_tot_s};
              RESULT_VALID <= 1'b1;
              TRY_CNT      <= try_next_s;
              BUSY         <= 1'b0;
              guess_r      <= '0;
              guess_cnt_r  <= 2'd0;
              jcnt_r       <= 2'd0;
              if (s_tot_s == 2'd3) begin
                state_r <= WIN_ST;
                WIN     <= 1'b1;
              end else if (try_next_s == 4'(MAX_TRY)) begin
                state_r <= LOSE_ST;
                LOSE    <= 1'b1;
              end else begin
                state_r <= COLLECT;
              end
            end else begin
              s_acc_r <= s_tot_s;
              b_acc_r <= b_tot_s;
              jcnt_r  <= jcnt_r + 2'd1;
            end
          end
          IDLE, WIN_ST, LOSE_ST: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_judge.sv
// Randomized scoreboard bench for sb_judge: default instance plus a MAX_TRY=2 instance.
module tb_sb_judge;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        SECRET_LOAD;
  logic [11:0] SECRET;
  logic        KEY_VALID;
  logic [3:0]  KEY_DIGIT;
  logic        KEY_CLEAR;

  logic [2:0]  s0, b0, s1, b1;
  logic        rv0, rv1, win0, win1, lose0, lose1, busy0, busy1;
  logic [3:0]  try0, try1;

  always #5 CLK = ~CLK;

  sb_judge dut0 (
    .CLK(CLK), .RESETN(RESETN), .SECRET_LOAD(SECRET_LOAD), .SECRET(SECRET),
    .KEY_VALID(KEY_VALID), .KEY_DIGIT(KEY_DIGIT), .KEY_CLEAR(KEY_CLEAR),
    .S(s0), .B(b0), .RESULT_VALID(rv0), .TRY_CNT(try0),
    .WIN(win0), .LOSE(lose0), .BUSY(busy0)
  );

  sb_judge #(.MAX_TRY(2)) dut1 (
    .CLK(CLK), .RESETN(RESETN), .SECRET_LOAD(SECRET_LOAD), .SECRET(SECRET),
    .KEY_VALID(KEY_VALID), .KEY_DIGIT(KEY_DIGIT), .KEY_CLEAR(KEY_CLEAR),
    .S(s1), .B(b1), .RESULT_VALID(rv1), .TRY_CNT(try1),
    .WIN(win1), .LOSE(lose1), .BUSY(busy1)
  );

  typedef struct {
    int due;
    int s;
    int b;
    int tr;
    int win;
    int lose;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  localparam int M_IDLE = 0, M_COL = 1, M_JUD = 2, M_WIN = 3, M_LOSE = 4;

  int m_st[2];
  int m_sec[2][3];
  int m_g[2][3];
  int m_gn[2];
  int m_left[2];
  int m_s[2];
  int m_b[2];
  int m_try[2];
  int m_ps[2];
  int m_pb[2];
  int m_max[2];

  int n_cmp = 0;
  int n_fail = 0;
  int ncyc = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic bit sec_valid(input logic [11:0] v);
    int d[3];
    d[0] = int'(v[11:8]);
    d[1] = int'(v[7:4]);
    d[2] = int'(v[3:0]);
    for (int i = 0; i < 3; i++) if (d[i] > 9) return 1'b0;
    return (d[0] != d[1]) && (d[0] != d[2]) && (d[1] != d[2]);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_gn[k] = 0; m_left[k] = 0;
      m_s[k] = 0; m_b[k] = 0; m_try[k] = 0;
      for (int j = 0; j < 3; j++) m_sec[k][j] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Reference game rules applied for one clock edge of instance k.
  task automatic m_step(input int k, input bit ld, input logic [11:0] sec,
                        input bit kv, input int kd, input bit kc);
    exp_t e;
    int hit, sc, bc;
    if (ld && sec_valid(sec)) begin
      if (m_st[k] == M_JUD) begin
        if (k == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      end
      m_sec[k][0] = int'(sec[11:8]);
      m_sec[k][1] = int'(sec[7:4]);
      m_sec[k][2] = int'(sec[3:0]);
      m_s[k] = 0; m_b[k] = 0; m_try[k] = 0; m_gn[k] = 0;
      m_st[k] = M_COL;
      return;
    end
    case (m_st[k])
      M_COL: begin
        if (kc) m_gn[k] = 0;
        else if (kv && kd <= 9) begin
          hit = 0;
          for (int j = 0; j < m_gn[k]; j++) if (m_g[k][j] == kd) hit = 1;
          if (hit == 0) begin
            m_g[k][m_gn[k]] = kd;
            m_gn[k]++;
            if (m_gn[k] == 3) begin
              sc = 0; bc = 0;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  if (m_g[k][i] == m_sec[k][j]) begin
                    if (i == j) sc++; else bc++;
                  end
              m_ps[k] = sc; m_pb[k] = bc;
              m_st[k] = M_JUD; m_left[k] = 3;
              e.due = ncyc + 4; e.s = sc; e.b = bc; e.tr = m_try[k] + 1;
              e.win = (sc == 3) ? 1 : 0;
              e.lose = (sc != 3 && m_try[k] + 1 == m_max[k]) ? 1 : 0;
              if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
          end
        end
      end
      M_JUD: begin
        if (m_left[k] > 1) m_left[k]--;
        else begin
          m_s[k] = m_ps[k]; m_b[k] = m_pb[k]; m_try[k]++; m_gn[k] = 0;
          if (m_ps[k] == 3) m_st[k] = M_WIN;
          else if (m_try[k] == m_max[k]) m_st[k] = M_LOSE;
          else m_st[k] = M_COL;
        end
      end
      default: ;
    endcase
  endtask

  // Monitor for one instance: pulses against the scoreboard, levels against the model.
  task automatic mon(input int k, input logic rv, input logic [2:0] s, input logic [2:0] b,
                     input logic [3:0] tr, input logic w, input logic l, input logic bz);
    exp_t e;
    int have;
    have = (k == 0) ? q0.size() : q1.size();
    if (rv) begin
      if (have == 0) chk($sformatf("i%0d_spurious_rv", k), int'(rv), 0);
      else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("i%0d_rv_latency", k), ncyc, e.due);
        chk($sformatf("i%0d_res_s", k), int'(s), e.s);
        chk($sformatf("i%0d_res_b", k), int'(b), e.b);
        chk($sformatf("i%0d_res_try", k), int'(tr), e.tr);
        chk($sformatf("i%0d_res_win", k), int'(w), e.win);
        chk($sformatf("i%0d_res_lose", k), int'(l), e.lose);
      end
    end else if (have != 0) begin
      if (k == 0) e = q0[0]; else e = q1[0];
      if (e.due <= ncyc) begin
        chk($sformatf("i%0d_rv_missing", k), int'(rv), 1);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    chk($sformatf("i%0d_S", k), int'(s), m_s[k]);
    chk($sformatf("i%0d_B", k), int'(b), m_b[k]);
    chk($sformatf("i%0d_TRY_CNT", k), int'(tr), m_try[k]);
    chk($sformatf("i%0d_WIN", k), int'(w), (m_st[k] == M_WIN) ? 1 : 0);
    chk($sformatf("i%0d_LOSE", k), int'(l), (m_st[k] == M_LOSE) ? 1 : 0);
    chk($sformatf("i%0d_BUSY", k), int'(bz), (m_st[k] == M_JUD) ? 1 : 0);
  endtask

  always @(negedge CLK) begin
    ncyc++;
    mon(0, rv0, s0, b0, try0, win0, lose0, busy0);
    mon(1, rv1, s1, b1, try1, win1, lose1, busy1);
  end

  task automatic step(input bit ld, input logic [11:0] sec, input bit kv,
                      input logic [3:0] kd, input bit kc);
    SECRET_LOAD = ld; SECRET = sec; KEY_VALID = kv; KEY_DIGIT = kd; KEY_CLEAR = kc;
    @(posedge CLK);
    m_step(0, ld, sec, kv, int'(kd), kc);
    m_step(1, ld, sec, kv, int'(kd), kc);
    #1;
    SECRET_LOAD = 1'b0; KEY_VALID = 1'b0; KEY_CLEAR = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 12'h000, 1'b1, d, 1'b0);
  endtask

  task automatic load(input logic [11:0] v);
    step(1'b1, v, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, 4'd0, 1'b0);
  endtask

  function automatic logic [11:0] rand_secret();
    int d0, d1, d2;
    d0 = $urandom_range(0, 9);
    do d1 = $urandom_range(0, 9); while (d1 == d0);
    do d2 = $urandom_range(0, 9); while (d2 == d0 || d2 == d1);
    return {4'(d0), 4'(d1), 4'(d2)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    m_max[0] = 9;
    m_max[1] = 2;
    RESETN = 1'b0; SECRET_LOAD = 1'b0; SECRET = 12'h000;
    KEY_VALID = 1'b0; KEY_DIGIT = 4'd0; KEY_CLEAR = 1'b0;
    m_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK); #2;
    RESETN = 1'b1;
    @(posedge CLK); #1;

    // Keys ignored in IDLE, then a straight win; keys after the win are ignored.
    key(4'd1); key(4'd2); idle(2);
    load(12'h123); key(4'd1); key(4'd2); key(4'd3); idle(5);
    key(4'd4); key(4'd5); key(4'd6); idle(5);

    // All balls, then a miss; the MAX_TRY=2 instance loses and ignores keys.
    load(12'h123); key(4'd3); key(4'd1); key(4'd2); idle(5);
    key(4'd4); key(4'd5); key(4'd6); idle(5);
    key(4'd7); key(4'd8); key(4'd9); idle(5);
    load(12'h112); idle(2);
    load(12'h456); idle(2);

    // Duplicate and out-of-range digits dropped.
    load(12'h123); key(4'd1); key(4'd1); key(4'hA); key(4'd2); key(4'd3); idle(5);

    // Clear empties the partial guess; a coincident key is dropped.
    load(12'h457); key(4'd1); key(4'd2); step(1'b0, 12'h000, 1'b1, 4'd7, 1'b1);
    key(4'd4); key(4'd5); key(4'd6); idle(5);

    // Secret load during the judgement aborts it.
    load(12'h123); key(4'd9); key(4'd8); key(4'd7); idle(1);
    load(12'h789); idle(5);
    key(4'd7); key(4'd9); key(4'd8); idle(5);

    // Secret load wins over a coincident key.
    step(1'b1, 12'h321, 1'b1, 4'd5, 1'b0); key(4'd3); key(4'd2); key(4'd1); idle(5);

    // Reset in the second judge cycle after a prior non-zero result.
    load(12'h123); key(4'd4); key(4'd5); key(4'd1); idle(5);
    key(4'd1); key(4'd2); key(4'd4); idle(1);
    #2;
    RESETN = 1'b0;
    #1;
    chk("rst_S", int'(s0), 0);
    chk("rst_B", int'(b0), 0);
    chk("rst_TRY_CNT", int'(try0), 0);
    chk("rst_BUSY", int'(busy0), 0);
    chk("rst_RESULT_VALID", int'(rv0), 0);
    chk("rst_WIN", int'(win0), 0);
    chk("rst_LOSE", int'(lose1), 0);
    m_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK); #2;
    RESETN = 1'b1;
    @(posedge CLK); #1;
    key(4'd1); key(4'd2); key(4'd3); idle(8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) step(1'b1, rand_secret(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 1'b0);
      else if (r < 6) step(1'b1, 12'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 1'b0);
      else step(1'b0, 12'h000, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
                1'($urandom_range(0, 15) == 0));
    end
    idle(6);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
